// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache tag-check stage.
// Optional feature macro: TAG_PARITY_EN (adds an even-parity bit to each stored tag).
package cache_pkg;

    localparam int ENTRIES  = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int IDX_W    = $clog2(ENTRIES);
    localparam int TAG_W    = ADDR_W - IDX_W - OFFSET_W;

`ifdef TAG_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    localparam int RAM_W = TAG_W + PAR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } lookup_state_e;

    // Set index: the IDX_W bits just above the line offset.
    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: IDX_W];
    endfunction

    // Tag: everything above the index.
    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

`ifdef TAG_PARITY_EN
    // Parity bit that makes the XOR of tag plus parity equal to zero.
    function automatic logic even_par(input logic [TAG_W-1:0] tag);
        return ^tag;
    endfunction

    // A stored word is good when its overall XOR is zero.
    function automatic logic par_bad(input logic [RAM_W-1:0] word);
        return ^word;
    endfunction
`endif

endpackage

// File: rtl/tag_valid_array.sv
// Per-set valid bits kept in resettable flops, since the tag RAM holds garbage after reset.
module tag_valid_array #(
    parameter int ENTRIES = 256,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid
);

    logic [ENTRIES-1:0] valid_r;

    // Valid bit update: flush wins over any set/clear issued in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (flush) begin
            valid_r <= {ENTRIES{1'b0}};
        end else begin
            if (set_en) begin
                valid_r[set_idx] <= 1'b1;
            end
            if (clr_en) begin
                valid_r[clr_idx] <= 1'b0;
            end
        end
    end

    assign rd_valid = valid_r[rd_idx];

endmodule

// File: rtl/cache_tag_lookup.sv
// Tag-check stage: drives an external 1-cycle tag RAM, answers hit/miss, handles fills and flush.
// Optional feature macro: TAG_PARITY_EN (parity-protected tags, par_err pulse on corruption).
module cache_tag_lookup
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic [ADDR_W-1:0] resp_addr,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic              flush,
    output logic [IDX_W-1:0]  ram_addr,
    output logic              ram_wr,
    output logic [RAM_W-1:0]  ram_tag_in,
    input  logic [RAM_W-1:0]  ram_tag_out,
    output logic              par_err
);

    lookup_state_e     state_r;
    lookup_state_e     next_state_s;
    logic [ADDR_W-1:0] lat_addr_r;
    logic              resp_valid_r;
    logic              resp_hit_r;
    logic              accept_s;
    logic              set_en_s;
    logic              clr_en_s;
    logic              hit_s;
    logic              par_bad_s;
    logic              rd_valid_s;
    logic [IDX_W-1:0]  lat_idx_s;
    logic [TAG_W-1:0]  lat_tag_s;
    logic [RAM_W-1:0]  fill_word_s;

    assign lat_idx_s = idx_of(lat_addr_r);
    assign lat_tag_s = tag_of(lat_addr_r);
    assign accept_s  = (state_r == IDLE) && req_valid && !fill_valid && !flush;

`ifdef TAG_PARITY_EN
    assign fill_word_s = {even_par(tag_of(fill_addr)), tag_of(fill_addr)};
`else
    assign fill_word_s = tag_of(fill_addr);
`endif

    // A parity failure invalidates the offending line so it is refetched.
    assign clr_en_s = par_bad_s;

    tag_valid_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_valid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .set_en   (set_en_s),
        .set_idx  (idx_of(fill_addr)),
        .clr_en   (clr_en_s),
        .clr_idx  (lat_idx_s),
        .rd_idx   (lat_idx_s),
        .rd_valid (rd_valid_s)
    );

    // Next-state, RAM port control and hit evaluation.
    always_comb begin
        next_state_s = state_r;
        req_ready    = 1'b0;
        fill_ready   = 1'b0;
        ram_wr       = 1'b0;
        ram_addr     = lat_idx_s;
        ram_tag_in   = {RAM_W{1'b0}};
        set_en_s     = 1'b0;
        hit_s        = 1'b0;
        par_bad_s    = 1'b0;
        case (state_r)
            IDLE: begin
                fill_ready = 1'b1;
                req_ready  = !fill_valid && !flush;
                if (fill_valid) begin
                    ram_wr     = 1'b1;
                    ram_addr   = idx_of(fill_addr);
                    ram_tag_in = fill_word_s;
                    set_en_s   = 1'b1;
                end else begin
                    ram_addr = idx_of(req_addr);
                end
                if (accept_s) begin
                    next_state_s = LOOKUP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOOKUP: begin
                // A flush in this cycle means the line is already gone.
                hit_s = rd_valid_s && !flush && (ram_tag_out[TAG_W-1:0] == lat_tag_s);
`ifdef TAG_PARITY_EN
                par_bad_s = rd_valid_s && par_bad(ram_tag_out);
                if (par_bad_s) begin
                    hit_s = 1'b0;
                end else begin
                    hit_s = hit_s;
                end
`endif
                next_state_s = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the accepted request address; it doubles as the response address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr_r <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            lat_addr_r <= req_addr;
        end else begin
            lat_addr_r <= lat_addr_r;
        end
    end

    // Response registers: loaded from LOOKUP, held until the consumer takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
        end else if (state_r == LOOKUP) begin
            resp_valid_r <= 1'b1;
            resp_hit_r   <= hit_s;
        end else if ((state_r == RESP) && resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_hit_r   <= resp_hit_r;
        end else begin
            resp_valid_r <= resp_valid_r;
            resp_hit_r   <= resp_hit_r;
        end
    end

`ifdef TAG_PARITY_EN
    logic par_err_r;

    // One-cycle pulse for every corrupted valid tag seen in LOOKUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_r <= 1'b0;
        end else begin
            par_err_r <= par_bad_s;
        end
    end

    assign par_err = par_err_r;
`else
    assign par_err = 1'b0;
`endif

    assign resp_valid = resp_valid_r;
    assign resp_hit   = resp_hit_r;
    assign resp_addr  = lat_addr_r;

endmodule
